jelly_cpu_exe_latch: RTL
========================

JELLY_CPU_EXE_LATCH -- requirements
Module: jelly_cpu_exe_latch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of ALU result and store data.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, width of destination register index.
REQ-003 SHALL have parameter PC_WIDTH, default 32, width of instruction address.
REQ-004 SHALL have port clk, input, 1: the only clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1: discard held and incoming entries; leave TRAP state.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream (execute/ALU) handshake.
REQ-008 SHALL have port in_pc, input, PC_WIDTH: instruction address.
REQ-009 SHALL have port in_alu_data, input, DATA_WIDTH: ALU result (result or memory address).
REQ-010 SHALL have port in_alu_overflow, input, 1: ALU signed overflow flag.
REQ-011 SHALL have port in_trap_ovf_en, input, 1: the instruction traps on overflow (signed ADD/SUB).
REQ-012 SHALL have ports in_dst_en (input, 1) and in_dst_addr (input, REG_ADDR_WIDTH): register write-back request.
REQ-013 SHALL have ports in_mem_en, in_mem_we (input, 1 each), in_mem_size (input, 2; 00 byte, 01 half, 10 word) and in_store_data (input, DATA_WIDTH).
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream (memory stage) handshake.
REQ-015 SHALL have registered outputs out_pc, out_alu_data, out_dst_en, out_dst_addr, out_mem_en, out_mem_we, out_mem_size and out_store_data, each matching its input width.
REQ-016 SHALL have registered outputs out_exc_valid (1) and out_exc_code (2; 01 overflow, 10 load address error, 11 store address error).

Function
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally, in both states.
REQ-018 SHALL accept an entry on a rising edge with in_valid && in_ready.
REQ-019 SHALL present an accepted entry on the outputs in the next cycle, giving one-cycle latency.
REQ-020 SHALL hold all out_* signals stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid after an edge with out_valid && out_ready and no new accept.
REQ-022 SHALL define state RUN: accepted entries are classified as follows.
  - overflow: in_trap_ovf_en && in_alu_overflow -> code 01.
  - address error: in_mem_en && (half && addr[0], or word && addr[1:0] != 0, or size 11) -> code 10 when !in_mem_we, 11 when in_mem_we.
  - precedence: overflow has priority over address error.
REQ-023 SHALL, for an exception entry, set out_exc_valid=1 and out_exc_code to the classified code.
REQ-024 SHALL, for an exception entry, force out_dst_en=0 and out_mem_en=0 while still passing out_pc and out_alu_data.
REQ-025 SHALL, for an exception entry, move RUN -> TRAP.
REQ-026 SHALL define state TRAP: in_valid entries are accepted (in_ready per REQ-017) and discarded, so out_valid does not rise from them.
REQ-027 SHALL leave TRAP only on flush.
REQ-028 SHALL, on an edge with flush=1:
  - clear out_valid and out_exc_valid;
  - discard any concurrent in_valid entry;
  - enter RUN.
  flush overrides out_ready, in_valid and exception classification.
REQ-029 SHALL let an exception entry held under back-pressure stay until out_ready; the TRAP transition occurs at acceptance, not at hand-off.
REQ-030 SHALL allow back-to-back accept and hand-off in the same cycle (full throughput, no bubble).
REQ-031 SHALL treat in_mem_size and alignment as don't-care when in_mem_en=0, and SHALL never flag address error in that case.

Reset
REQ-032 SHALL, while reset_n=0, asynchronously force:
  - state RUN;
  - out_valid=0, out_exc_valid=0, out_exc_code=00;
  - out_dst_en=0, out_mem_en=0, out_mem_we=0;
  - out_pc, out_alu_data, out_dst_addr, out_mem_size and out_store_data all zero.
REQ-033 SHALL accept a new entry on the first edge after reset_n rises if in_valid=1; reset mid-TRAP returns to RUN with no pending output.

Verification
REQ-034 SHALL cover basic pass-through: in_valid=1, alu_data=0x00001234, dst_en=1, dst_addr=5, out_ready=1 -> next cycle out_valid=1, out_alu_data=0x00001234, out_dst_addr=5, exc_valid=0.
REQ-035 SHALL cover back-pressure: out_ready=0 for 3 cycles with a second entry offered -> in_ready=0, outputs unchanged; out_ready=1 -> first entry handed off, second captured the same edge.
REQ-036 SHALL cover overflow trap: trap_ovf_en=1, overflow=1, dst_en=1 -> out_exc_valid=1, code 01, out_dst_en=0; 3 subsequent in_valid entries -> out_valid=0; then flush -> next entry passes normally.
REQ-037 SHALL cover alignment:
  - word load at 0x00000102 -> code 10, out_mem_en=0;
  - half store at 0x00000103 -> code 11;
  - word at 0x00000104 -> no exception.
REQ-038 SHALL cover simultaneous events: flush=1 with in_valid=1 and a held entry -> next cycle out_valid=0, state RUN; overflow with misaligned word -> code 01.
REQ-039 SHALL cover reset: reset_n pulsed low mid-TRAP with out_valid=1 -> outputs immediately zero (no clock edge needed), state RUN.

Source files
------------

// File: rtl/jelly_cpu_exe_latch.sv
// rtl/jelly_cpu_exe_latch.sv - execute-to-memory pipeline latch with overflow/alignment trap
// One-entry skid-free register slice; an exception entry parks the stage in TRAP until flush.
module jelly_cpu_exe_latch #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [DATA_WIDTH-1:0]     in_alu_data,
  input  logic                      in_alu_overflow,
  input  logic                      in_trap_ovf_en,
  input  logic                      in_dst_en,
  input  logic [REG_ADDR_WIDTH-1:0] in_dst_addr,
  input  logic                      in_mem_en,
  input  logic                      in_mem_we,
  input  logic [1:0]                in_mem_size,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [DATA_WIDTH-1:0]     out_alu_data,
  output logic                      out_dst_en,
  output logic [REG_ADDR_WIDTH-1:0] out_dst_addr,
  output logic                      out_mem_en,
  output logic                      out_mem_we,
  output logic [1:0]                out_mem_size,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic                      out_exc_valid,
  output logic [1:0]                out_exc_code
);

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic                        valid_q, valid_d;
  logic [PC_WIDTH-1:0]         pc_q, pc_d;
  logic [DATA_WIDTH-1:0]       alu_q, alu_d;
  logic                        dst_en_q, dst_en_d;
  logic [REG_ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
  logic                        mem_en_q, mem_en_d;
  logic                        mem_we_q, mem_we_d;
  logic [1:0]                  mem_size_q, mem_size_d;
  logic [DATA_WIDTH-1:0]       store_q, store_d;
  logic                        exc_valid_q, exc_valid_d;
  logic [1:0]                  exc_code_q, exc_code_d;

  logic       capture;
  logic       misaligned;
  logic       exc_any;
  logic [1:0] exc_code;

  assign in_ready = !valid_q || out_ready;
  // Only RUN keeps what it accepts; TRAP swallows entries, flush swallows everything.
  assign capture  = in_valid && in_ready && (state_q == ST_RUN) && !flush;

  always_comb begin
    case (in_mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_alu_data[0];
      2'b10:   misaligned = |in_alu_data[1:0];
      default: misaligned = 1'b1;
    endcase
    if (in_trap_ovf_en && in_alu_overflow) begin
      exc_code = 2'b01;
    end else if (in_mem_en && misaligned) begin
      exc_code = in_mem_we ? 2'b11 : 2'b10;
    end else begin
      exc_code = 2'b00;
    end
    exc_any = (exc_code != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else if (capture && exc_any) begin
      state_d = ST_TRAP;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    dst_en_d    = dst_en_q;
    dst_addr_d  = dst_addr_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    store_d     = store_q;
    exc_valid_d = exc_valid_q;
    exc_code_d  = exc_code_q;
    if (flush) begin
      valid_d     = 1'b0;
      exc_valid_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      pc_d        = in_pc;
      alu_d       = in_alu_data;
      dst_en_d    = in_dst_en && !exc_any;
      dst_addr_d  = in_dst_addr;
      mem_en_d    = in_mem_en && !exc_any;
      mem_we_d    = in_mem_we;
      mem_size_d  = in_mem_size;
      store_d     = in_store_data;
      exc_valid_d = exc_any;
      exc_code_d  = exc_code;
    end else if (out_ready) begin
      valid_d     = 1'b0;
      exc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      alu_q       <= '0;
      dst_en_q    <= 1'b0;
      dst_addr_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      store_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= 2'b00;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      dst_en_q    <= dst_en_d;
      dst_addr_q  <= dst_addr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      store_q     <= store_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_alu_data   = alu_q;
  assign out_dst_en     = dst_en_q;
  assign out_dst_addr   = dst_addr_q;
  assign out_mem_en     = mem_en_q;
  assign out_mem_we     = mem_we_q;
  assign out_mem_size   = mem_size_q;
  assign out_store_data = store_q;
  assign out_exc_valid  = exc_valid_q;
  assign out_exc_code   = exc_code_q;

endmodule
